// File: rtl/rca_pkg.sv
// Shared types and constants for the sequential wide ripple-carry adder.
package rca_pkg;

  localparam int CHUNK_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Counter width for n chunks; never below one bit so a single-chunk build still has a counter
  function automatic int cnt_width(input int nchunk);
    int w;
    w = 1;
    while ((1 << w) < nchunk) w++;
    return w;
  endfunction

endpackage

// File: rtl/rca_wide_add_seq_if.sv
// Operand/result handshake bundle for rca_wide_add_seq.
// RCA_WIDE_SUB_EN adds the in_sub request bit.
interface rca_wide_add_seq_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
`ifdef RCA_WIDE_SUB_EN
  logic             in_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

`ifdef RCA_WIDE_SUB_EN
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`endif

endinterface

// File: rtl/ripple_carry_adder_4bit.sv
// Combinational 4-bit ripple-carry adder slice.
module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  // The carry is walked bit by bit through a local variable
  always_comb begin
    logic c;
    sum = '0;
    c   = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/rca_wide_add_seq.sv
// Multi-cycle WIDTH-bit adder that pushes one 4-bit chunk per cycle through a single slice.
// Define RCA_WIDE_SUB_EN to enable subtraction via bus.in_sub.
module rca_wide_add_seq
  import rca_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  rca_wide_add_seq_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK_W;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  generate
    if (WIDTH < CHUNK_W || (WIDTH % CHUNK_W) != 0) begin : g_bad_width
      $error("rca_wide_add_seq: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         cnt;
  logic [WIDTH-1:0]      a_sh;
  logic [WIDTH-1:0]      b_sh;
  logic [WIDTH-1:0]      res;
  logic                  carry;
  logic                  a_msb;
  logic                  b_msb;
  logic [WIDTH-1:0]      b_cap;
  logic                  c_cap;
  logic [CHUNK_W-1:0]    s_sum;
  logic                  s_cout;
  logic [WIDTH+CHUNK_W-1:0] res_cat;
  logic                  in_ready_q;
  logic                  out_valid_q;

  // Subtraction folds into addition by inverting b and forcing the initial carry
`ifdef RCA_WIDE_SUB_EN
  assign b_cap = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign c_cap = bus.in_sub ? 1'b1 : bus.in_cin;
`else
  assign b_cap = bus.in_b;
  assign c_cap = bus.in_cin;
`endif

  ripple_carry_adder_4bit u_slice (
    .a    (a_sh[CHUNK_W-1:0]),
    .b    (b_sh[CHUNK_W-1:0]),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout)
  );

  assign res_cat = {s_sum, res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.in_valid)   state_nxt = RUN;
      RUN:  if (cnt == LAST)    state_nxt = DONE;
      DONE: if (bus.out_ready)  state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_q  = (state == IDLE);
    out_valid_q = (state == DONE);
  end

  // Operands shift right so the slice always sees the current chunk in the low nibble;
  // the MSBs are kept aside because the overflow term needs them after the shifts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      cnt   <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      a_sh  <= bus.in_a;
      b_sh  <= b_cap;
      carry <= c_cap;
      a_msb <= bus.in_a[WIDTH-1];
      b_msb <= b_cap[WIDTH-1];
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> CHUNK_W;
      b_sh  <= b_sh >> CHUNK_W;
      res   <= res_cat[WIDTH+CHUNK_W-1:CHUNK_W];
      carry <= s_cout;
      cnt   <= cnt + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = res;
  assign bus.out_cout  = carry;
  assign bus.out_ovf   = carry ^ (a_msb ^ b_msb ^ res[WIDTH-1]);

endmodule
